dds_sweep_ctrl: RTL

//  Upstream configuration sequencer for cordic_dds. Steps the frequency word from START to STOP in

---
 rtl/dds_sweep_ctrl.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: configuration sequencer for cordic_dds. It steps a frequency word from a
// start value to a stop value in fixed increments and holds each tone for a programmable
// number of clocks. On each tone change it issues a one-cycle update strobe with the
// frequency and phase words. It can run a single sweep or repeat the sweep continuously.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   start, abort     start pulse (honoured in IDLE only), abort (any active state -> IDLE)
//   cfg_mode         0 = single sweep, 1 = continuous (wrap back to start word)
//   cfg_start_word   first frequency word
//   cfg_stop_word    inclusive upper bound on emitted frequency words
//   cfg_step_word    unsigned increment per step
//   cfg_dwell        clocks per tone (0 behaves as 1)
//   cfg_phase        phase word sent with every strobe
//   busy             sweep in progress
//   done             one-cycle pulse when a single sweep ends
//   dds_cfg_vld      one-cycle update strobe to cordic_dds
//   dds_freq_word    frequency word, held between strobes
//   dds_phase_word   phase word, held between strobes
//   step_idx         index of the current tone (0 = start word), saturating
module dds_sweep_ctrl #(
  parameter int unsigned FREQ_WIDTH  = 32,
  parameter int unsigned PHASE_WIDTH = 32,
  parameter int unsigned DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   cfg_mode,
  input  logic [FREQ_WIDTH-1:0]  cfg_start_word,
  input  logic [FREQ_WIDTH-1:0]  cfg_stop_word,
  input  logic [FREQ_WIDTH-1:0]  cfg_step_word,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic [PHASE_WIDTH-1:0] cfg_phase,
  output logic                   busy,
  output logic                   done,
  output logic                   dds_cfg_vld,
  output logic [FREQ_WIDTH-1:0]  dds_freq_word,
  output logic [PHASE_WIDTH-1:0] dds_phase_word,
  output logic [15:0]            step_idx
);

  localparam int unsigned IDX_WIDTH = 16;
  localparam int unsigned SUM_WIDTH = FREQ_WIDTH + 1;

  // EMIT: cycle in which a strobe is visible; DWELL: holding a tone; FINISH: done pulse cycle
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EMIT   = 2'd1,
    ST_DWELL  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t                 state_q, state_d;

  // Shadow copies of the configuration, captured on an accepted start
  logic [FREQ_WIDTH-1:0]  start_w_q, start_w_d;
  logic [FREQ_WIDTH-1:0]  stop_w_q, stop_w_d;
  logic [FREQ_WIDTH-1:0]  step_w_q, step_w_d;
  logic [DWELL_WIDTH-1:0] dwell_m1_q, dwell_m1_d;
  logic                   mode_q, mode_d;
  logic [PHASE_WIDTH-1:0] phase_w_q, phase_w_d;

  // Clocks remaining before the next tone event
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;

  // Registered outputs
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   vld_q, vld_d;
  logic [FREQ_WIDTH-1:0]  freq_q, freq_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;

  logic [SUM_WIDTH-1:0]   sum_c;
  logic                   adv_ok_c;
  logic [DWELL_WIDTH-1:0] cfg_dwell_m1_c;
  logic [IDX_WIDTH-1:0]   idx_inc_c;

  // Next tone word with carry; a carry, an overshoot of stop or a zero step ends the sweep
  always_comb begin
    sum_c    = {1'b0, freq_q} + {1'b0, step_w_q};
    adv_ok_c = !sum_c[FREQ_WIDTH]
               && (sum_c[FREQ_WIDTH-1:0] <= stop_w_q)
               && (step_w_q != '0);
  end

  // Dwell of 0 behaves like 1, so the reload value is clamped at 0
  always_comb begin
    if (cfg_dwell == '0) begin
      cfg_dwell_m1_c = '0;
    end else begin
      cfg_dwell_m1_c = cfg_dwell - DWELL_WIDTH'(1);
    end
  end

  // Saturating tone index
  always_comb begin
    if (idx_q == '1) begin
      idx_inc_c = idx_q;
    end else begin
      idx_inc_c = idx_q + IDX_WIDTH'(1);
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    start_w_d  = start_w_q;
    stop_w_d   = stop_w_q;
    step_w_d   = step_w_q;
    dwell_m1_d = dwell_m1_q;
    mode_d     = mode_q;
    phase_w_d  = phase_w_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    vld_d      = 1'b0;
    freq_d     = freq_q;
    phase_d    = phase_q;
    idx_d      = idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          start_w_d  = cfg_start_word;
          stop_w_d   = cfg_stop_word;
          step_w_d   = cfg_step_word;
          dwell_m1_d = cfg_dwell_m1_c;
          mode_d     = cfg_mode;
          phase_w_d  = cfg_phase;
          cnt_d      = cfg_dwell_m1_c;
          busy_d     = 1'b1;
          vld_d      = 1'b1;
          freq_d     = cfg_start_word;
          phase_d    = cfg_phase;
          idx_d      = '0;
          state_d    = ST_EMIT;
        end
      end

      ST_EMIT, ST_DWELL: begin
        if (abort) begin
          // Abort wins over any strobe due on this edge
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d   = cnt_q - DWELL_WIDTH'(1);
          state_d = ST_DWELL;
        end else if (adv_ok_c) begin
          vld_d   = 1'b1;
          freq_d  = sum_c[FREQ_WIDTH-1:0];
          phase_d = phase_w_q;
          idx_d   = idx_inc_c;
          cnt_d   = dwell_m1_q;
          state_d = ST_EMIT;
        end else if (mode_q) begin
          // Continuous mode wraps to the start word in the slot of the would-be next tone
          vld_d   = 1'b1;
          freq_d  = start_w_q;
          phase_d = phase_w_q;
          idx_d   = '0;
          cnt_d   = dwell_m1_q;
          state_d = ST_EMIT;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_FINISH;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      start_w_q  <= '0;
      stop_w_q   <= '0;
      step_w_q   <= '0;
      dwell_m1_q <= '0;
      mode_q     <= 1'b0;
      phase_w_q  <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      vld_q      <= 1'b0;
      freq_q     <= '0;
      phase_q    <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      start_w_q  <= start_w_d;
      stop_w_q   <= stop_w_d;
      step_w_q   <= step_w_d;
      dwell_m1_q <= dwell_m1_d;
      mode_q     <= mode_d;
      phase_w_q  <= phase_w_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      vld_q      <= vld_d;
      freq_q     <= freq_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign dds_cfg_vld    = vld_q;
  assign dds_freq_word  = freq_q;
  assign dds_phase_word = phase_q;
  assign step_idx       = idx_q;

endmodule
